// File: rtl/uart_buf_ctrl_pkg.sv
// Shared types and default sizes for the UART buffer controller.
package uart_buf_ctrl_pkg;
   localparam int DATA_BITS_DEF = 8;
   localparam int FIFO_DEF      = 4;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_ACK,
      WAIT_DONE
   } tx_state_t;
endpackage

// File: rtl/byte_queue.sv
// Shift-register byte queue: head at index 0, push appends at the tail,
// pop shifts toward the head; push and pop may happen in the same cycle.
module byte_queue
   import uart_buf_ctrl_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF,
   parameter int FIFO      = FIFO_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [DATA_BITS-1:0]       push_data,
   input  logic                       pop,
   output logic [DATA_BITS-1:0]       q [0:FIFO-1],
   output logic [$clog2(FIFO+1)-1:0]  count,
   output logic                       full
);
   localparam int CNT_W = $clog2(FIFO+1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   logic [DATA_BITS-1:0] q_nxt [0:FIFO-1];
   logic [CNT_W-1:0]     cnt_nxt;
   logic [CNT_W-1:0]     wr_idx;
   logic                 pop_ok;
   logic                 push_ok;

   assign pop_ok = pop && (count != '0);
   assign full   = (count == FULL_CNT);

   // A push while full is only accepted when a pop frees the tail slot.
   always_comb begin
      q_nxt   = q;
      push_ok = push && ((count != FULL_CNT) || pop_ok);
      if (pop_ok) begin
         for (int i = 0; i < FIFO-1; i++) q_nxt[i] = q[i+1];
         q_nxt[FIFO-1] = '0;
      end
      wr_idx = pop_ok ? (count - ONE) : count;
      if (push_ok) begin
         for (int i = 0; i < FIFO; i++) begin
            if (CNT_W'(i) == wr_idx) q_nxt[i] = push_data;
         end
      end
      cnt_nxt = count;
      if (push_ok && !pop_ok)      cnt_nxt = count + ONE;
      else if (!push_ok && pop_ok) cnt_nxt = count - ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO; i++) q[i] <= '0;
         count <= '0;
      end else begin
         q     <= q_nxt;
         count <= cnt_nxt;
      end
   end
endmodule

// File: rtl/uart_buf_ctrl.sv
// UART buffer controller: TX queue drained through a handshake FSM toward a
// UART transmitter, plus an independent newest-first RX history.
module uart_buf_ctrl
   import uart_buf_ctrl_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF,
   parameter int FIFO      = FIFO_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       load_req,
   input  logic [DATA_BITS-1:0]       load_data,
   input  logic                       send_req,
   input  logic                       clr_rx,
   input  logic                       tx_ready,
   output logic                       tx_start,
   output logic [DATA_BITS-1:0]       tx_data,
   input  logic                       rx_valid,
   input  logic [DATA_BITS-1:0]       rx_data,
   output logic [DATA_BITS-1:0]       TXBUF [0:FIFO-1],
   output logic [DATA_BITS-1:0]       RXBUF [0:FIFO-1],
   output logic [$clog2(FIFO+1)-1:0]  tx_count,
   output logic [$clog2(FIFO+1)-1:0]  rx_count,
   output logic                       tx_full,
   output logic                       busy,
   output logic                       rx_overflow
);
   localparam int CNT_W = $clog2(FIFO+1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   tx_state_t state;
   logic      pop;
   logic      more_left;

   assign pop       = (state == WAIT_DONE) && tx_ready;
   // A load in the pop cycle is always accepted, so it keeps the drain going.
   assign more_left = (tx_count > ONE) || load_req;
   assign tx_data   = TXBUF[0];

   byte_queue #(
      .DATA_BITS (DATA_BITS),
      .FIFO      (FIFO)
   ) u_tx_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (load_req),
      .push_data (load_data),
      .pop       (pop),
      .q         (TXBUF),
      .count     (tx_count),
      .full      (tx_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         tx_start <= 1'b0;
         busy     <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         case (state)
            IDLE: begin
               if (send_req && (tx_count != '0)) begin
                  state <= START;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (tx_ready) begin
                  tx_start <= 1'b1;
                  state    <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (!tx_ready) state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (tx_ready) begin
                  if (more_left) begin
                     state <= START;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // RX history: clear takes priority, but a byte arriving with the clear is kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO; i++) RXBUF[i] <= '0;
         rx_count    <= '0;
         rx_overflow <= 1'b0;
      end else if (clr_rx) begin
         for (int i = 0; i < FIFO; i++) RXBUF[i] <= '0;
         rx_overflow <= 1'b0;
         if (rx_valid) begin
            RXBUF[0] <= rx_data;
            rx_count <= ONE;
         end else begin
            rx_count <= '0;
         end
      end else if (rx_valid) begin
         RXBUF[0] <= rx_data;
         for (int i = 1; i < FIFO; i++) RXBUF[i] <= RXBUF[i-1];
         if (rx_count == FULL_CNT) rx_overflow <= 1'b1;
         else                      rx_count    <= rx_count + ONE;
      end
   end
endmodule

// File: tb/tb_uart_buf_ctrl.sv
// Scoreboard bench for uart_buf_ctrl: queued expected TX bytes are checked by a
// monitor on every tx_start; static buffer/flag state is checked directly.
module tb_uart_buf_ctrl;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       load_req, send_req, clr_rx, rx_valid;
   logic [7:0] load_data, rx_data;
   logic       tx_ready, tx_start, tx_full, busy, rx_overflow;
   logic [7:0] tx_data;
   logic [7:0] TXBUF [0:3];
   logic [7:0] RXBUF [0:3];
   logic [2:0] tx_count, rx_count;

   int         checks = 0;
   int         failures = 0;
   int         tx_pulses = 0;
   int         p0;
   logic [7:0] exp_q [$];
   logic [7:0] mon_exp;
   logic       model_en = 1'b1;
   logic       model_ready = 1'b1;
   logic       man_ready = 1'b1;

   always #5 clk = ~clk;
   assign tx_ready = model_en ? model_ready : man_ready;

   uart_buf_ctrl #(.DATA_BITS(8), .FIFO(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_req    (load_req),
      .load_data   (load_data),
      .send_req    (send_req),
      .clr_rx      (clr_rx),
      .tx_ready    (tx_ready),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .TXBUF       (TXBUF),
      .RXBUF       (RXBUF),
      .tx_count    (tx_count),
      .rx_count    (rx_count),
      .tx_full     (tx_full),
      .busy        (busy),
      .rx_overflow (rx_overflow)
   );

   // UART transmitter model: goes busy 2 cycles after tx_start, idle 10 later.
   always begin
      @(negedge clk);
      if (model_en && rst_n && tx_start) begin
         repeat (2) @(negedge clk);
         model_ready = 1'b0;
         repeat (10) @(negedge clk);
         model_ready = 1'b1;
      end
   end

   // Scoreboard monitor: every tx_start must match the next expected byte.
   always @(negedge clk) begin
      if (rst_n && tx_start) begin
         tx_pulses++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL tx_unexpected: tx_start with tx_data=%0h, required no tx_start", tx_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (tx_data !== mon_exp) begin
               failures++;
               $display("FAIL tx_data: got %0h required %0h", tx_data, mon_exp);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic load(input logic [7:0] b);
      load_req  = 1'b1;
      load_data = b;
      @(negedge clk);
      load_req  = 1'b0;
   endtask

   task automatic send();
      send_req = 1'b1;
      @(negedge clk);
      send_req = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      int n = 0;
      while (busy && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy) begin
         failures++;
         $display("FAIL wait_idle_timeout: busy=%0b after %0d cycles, required 0", busy, max_cyc);
      end
   endtask

   task automatic wait_tx_start(input int max_cyc);
      int n = 0;
      while (!tx_start && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!tx_start) begin
         failures++;
         $display("FAIL wait_tx_start_timeout: tx_start=%0b after %0d cycles, required 1", tx_start, max_cyc);
      end
   endtask

   initial begin
      rst_n = 1'b0; load_req = 1'b0; send_req = 1'b0; clr_rx = 1'b0;
      rx_valid = 1'b0; load_data = '0; rx_data = '0;
      repeat (2) @(negedge clk);

      // Reset state, sampled while reset is held
      chk("rst_busy",     32'(busy), 0);
      chk("rst_tx_start", 32'(tx_start), 0);
      chk("rst_tx_full",  32'(tx_full), 0);
      chk("rst_rx_ovf",   32'(rx_overflow), 0);
      chk("rst_tx_count", 32'(tx_count), 0);
      chk("rst_rx_count", 32'(rx_count), 0);
      chk("rst_txbuf0",   32'(TXBUF[0]), 0);
      chk("rst_rxbuf0",   32'(RXBUF[0]), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Three-byte send with handshaking transmitter
      p0 = tx_pulses;
      load(8'h41); exp_q.push_back(8'h41);
      load(8'h42); exp_q.push_back(8'h42);
      load(8'h43); exp_q.push_back(8'h43);
      chk("t1_count_loaded", 32'(tx_count), 3);
      send();
      chk("t1_busy_started", 32'(busy), 1);
      wait_idle(400);
      chk("t1_pulses",  32'(tx_pulses - p0), 3);
      chk("t1_busy",    32'(busy), 0);
      chk("t1_count",   32'(tx_count), 0);
      chk("t1_exp_left", 32'(exp_q.size()), 0);

      // Overfill: fifth byte dropped
      for (int b = 1; b <= 5; b++) load(8'(b));
      chk("t2_count",  32'(tx_count), 4);
      chk("t2_full",   32'(tx_full), 1);
      chk("t2_txbuf0", 32'(TXBUF[0]), 32'h01);
      chk("t2_txbuf1", 32'(TXBUF[1]), 32'h02);
      chk("t2_txbuf2", 32'(TXBUF[2]), 32'h03);
      chk("t2_txbuf3", 32'(TXBUF[3]), 32'h04);

      // Load while full in the pop cycle: accepted, count stays 4
      exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
      exp_q.push_back(8'h04); exp_q.push_back(8'h99);
      p0 = tx_pulses;
      model_en  = 1'b0;
      man_ready = 1'b1;
      send();
      wait_tx_start(20);
      man_ready = 1'b0;
      @(negedge clk);
      man_ready = 1'b1;
      load(8'h99);
      chk("t3_count",  32'(tx_count), 4);
      chk("t3_full",   32'(tx_full), 1);
      chk("t3_txbuf0", 32'(TXBUF[0]), 32'h02);
      chk("t3_txbuf3", 32'(TXBUF[3]), 32'h99);
      model_en = 1'b1;
      wait_idle(800);
      chk("t3_pulses",   32'(tx_pulses - p0), 5);
      chk("t3_count_end", 32'(tx_count), 0);
      chk("t3_exp_left", 32'(exp_q.size()), 0);

      // RX history, overflow, and clear with simultaneous byte
      for (int b = 8'h10; b <= 8'h14; b++) begin
         rx_valid = 1'b1;
         rx_data  = 8'(b);
         @(negedge clk);
      end
      rx_valid = 1'b0;
      chk("t4_rxbuf0", 32'(RXBUF[0]), 32'h14);
      chk("t4_rxbuf1", 32'(RXBUF[1]), 32'h13);
      chk("t4_rxbuf2", 32'(RXBUF[2]), 32'h12);
      chk("t4_rxbuf3", 32'(RXBUF[3]), 32'h11);
      chk("t4_rx_count", 32'(rx_count), 4);
      chk("t4_rx_ovf",   32'(rx_overflow), 1);
      clr_rx = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
      @(negedge clk);
      clr_rx = 1'b0; rx_valid = 1'b0;
      chk("t4c_rxbuf0", 32'(RXBUF[0]), 32'h55);
      chk("t4c_rxbuf1", 32'(RXBUF[1]), 0);
      chk("t4c_rxbuf3", 32'(RXBUF[3]), 0);
      chk("t4c_rx_count", 32'(rx_count), 1);
      chk("t4c_rx_ovf",   32'(rx_overflow), 0);

      // Reset while waiting for the transmitter to finish
      load(8'hAA); exp_q.push_back(8'hAA);
      load(8'hBB);
      send();
      wait_tx_start(20);
      repeat (4) @(negedge clk);
      chk("t5_in_send", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("t5_busy",     32'(busy), 0);
      chk("t5_count",    32'(tx_count), 0);
      chk("t5_txbuf0",   32'(TXBUF[0]), 0);
      chk("t5_txbuf1",   32'(TXBUF[1]), 0);
      chk("t5_tx_start", 32'(tx_start), 0);
      @(negedge clk);
      rst_n = 1'b1;
      p0 = tx_pulses;
      repeat (30) @(negedge clk);
      chk("t5_no_pulse", 32'(tx_pulses - p0), 0);
      chk("t5_busy_after", 32'(busy), 0);

      // Send with empty queue is ignored
      p0 = tx_pulses;
      send();
      chk("t6_busy", 32'(busy), 0);
      repeat (5) @(negedge clk);
      chk("t6_busy_later", 32'(busy), 0);
      chk("t6_no_pulse", 32'(tx_pulses - p0), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
